// File: rtl/uart_console_pkg.sv
// Shared state encoding and constants for the UART console byte sink.
// Build option: define UART_CONSOLE_PARITY_EN to add an even-parity bit to every frame.
package uart_console_pkg;

    localparam logic [31:0] DEFAULT_CONSOLE_ADDRESS = 32'h1000_0000;
    localparam logic        ACCESS_WRITE            = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_CONSOLE_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

    function automatic logic even_parity(input logic [7:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/uart_console_fifo.sv
// Byte FIFO for the console; pointers carry one extra wrap bit so full and empty differ.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_console_fifo #(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop,
    output logic [7:0]    pop_data,
    output logic          full,
    output logic          empty,
    output logic          dropped,
    output logic [AW:0]   count
);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count    = wr_ptr_q - rd_ptr_q;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign dropped  = push && !do_push;
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_console.sv
// Memory-mapped console: bytes stored to CONSOLE_ADDRESS are buffered and sent 8N1 on tx.
// Build option: UART_CONSOLE_PARITY_EN inserts an even-parity bit (8E1, 11-bit frames).
module uart_console
    import uart_console_pkg::*;
#(
    parameter logic [31:0] CONSOLE_ADDRESS = DEFAULT_CONSOLE_ADDRESS,
    parameter int          CLKS_PER_BIT    = 16,
    parameter int          FIFO_DEPTH      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_data,
    output logic        tx,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow
);

    localparam int          CW          = $clog2(FIFO_DEPTH);
    localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state_q;
    logic [15:0] baud_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        overflow_q, overflow_d;
`ifdef UART_CONSOLE_PARITY_EN
    logic        parity_q;
`endif

    logic        push_req, pop, bit_done;
    logic        fifo_empty, fifo_dropped;
    logic [7:0]  fifo_data;
    logic [CW:0] fifo_count;
    logic        unused_inputs;

    assign push_req = data_memory_interface_enable
                   && (data_memory_interface_state == ACCESS_WRITE)
                   && (data_memory_interface_address == CONSOLE_ADDRESS)
                   && data_memory_interface_frame_mask[3];

    assign bit_done = (baud_q == '0);
    // Pop when idle, or at the end of a stop bit so frames run back to back.
    assign pop      = !fifo_empty && ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));

    assign unused_inputs = ^{data_memory_interface_data[31:8], data_memory_interface_frame_mask[2:0], fifo_count};

    uart_console_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (data_memory_interface_data[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .dropped   (fifo_dropped),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_CONSOLE_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else if (pop) begin
            state_q   <= ST_START;
            baud_q    <= BAUD_RELOAD;
            bit_cnt_q <= '0;
            shift_q   <= fifo_data;
            tx_q      <= 1'b0;
`ifdef UART_CONSOLE_PARITY_EN
            parity_q  <= even_parity(fifo_data);
`endif
        end else if (state_q != ST_IDLE) begin
            if (!bit_done) begin
                baud_q <= baud_q - 16'd1;
            end else begin
                baud_q <= BAUD_RELOAD;
                case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                        tx_q    <= shift_q[0];
                    end
                    ST_DATA: begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
`ifdef UART_CONSOLE_PARITY_EN
                            state_q <= ST_PARITY;
                            tx_q    <= parity_q;
`else
                            state_q <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
`ifdef UART_CONSOLE_PARITY_EN
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        tx_q    <= 1'b1;
                    end
`endif
                    default: begin
                        state_q <= ST_IDLE;
                        tx_q    <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign overflow_d = overflow_q | fifo_dropped;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign tx       = tx_q;
    assign busy     = !fifo_empty || (state_q != ST_IDLE);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_console.sv
// Self-checking bench for uart_console: a serial-line monitor decodes tx frames and
// tests compare them with a byte-queue model of what the console should have accepted.
module tb_uart_console;

    localparam int          CPB      = 4;
    localparam int          DEPTH    = 16;
    localparam logic [31:0] CON_ADDR = 32'h1000_0000;
`ifdef UART_CONSOLE_PARITY_EN
    localparam int          FB       = 11;
`else
    localparam int          FB       = 10;
`endif
    localparam int          FRAME_CYC = FB * CPB;

    logic        clk;
    logic        reset;
    logic        mem_en;
    logic        mem_state;
    logic [31:0] mem_addr;
    logic [3:0]  mem_mask;
    logic [31:0] mem_data;
    logic        tx, busy, fifo_full, overflow;

    int compared;
    int mismatched;

    // Reference model: bytes the console must emit, in order, plus expected overflow.
    logic [7:0]  exp_q[$];
    int          model_acc;
    logic        model_drop;

    // Monitor results, decoded purely from the tx line.
    logic [7:0]  rx_bytes[$];
    logic [10:0] rx_raw[$];
    logic        rx_par[$];
    int          start_cycles[$];
    int          frames_started;
    int          mon_errors;
    int          cyc;

    uart_console #(
        .CONSOLE_ADDRESS (CON_ADDR),
        .CLKS_PER_BIT    (CPB),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk                              (clk),
        .reset                            (reset),
        .data_memory_interface_enable     (mem_en),
        .data_memory_interface_state      (mem_state),
        .data_memory_interface_address    (mem_addr),
        .data_memory_interface_frame_mask (mem_mask),
        .data_memory_interface_data       (mem_data),
        .tx                               (tx),
        .busy                             (busy),
        .fifo_full                        (fifo_full),
        .overflow                         (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Line monitor: samples tx on falling edges, checks every bit is held CPB samples.
    initial begin
        bit          mon_active;
        int          mon_idx;
        logic [10:0] mon_bits;
        mon_active = 1'b0;
        mon_idx = 0;
        mon_bits = '1;
        frames_started = 0;
        mon_errors = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
            end else begin
                if (!mon_active && tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_idx = 0;
                    mon_bits = '1;
                    frames_started = frames_started + 1;
                    start_cycles.push_back(cyc);
                end
                if (mon_active) begin
                    if (mon_idx % CPB == 0) mon_bits[mon_idx / CPB] = tx;
                    else if (tx !== mon_bits[mon_idx / CPB]) mon_errors = mon_errors + 1;
                    mon_idx = mon_idx + 1;
                    if (mon_idx == FRAME_CYC) begin
                        mon_active = 1'b0;
                        if (mon_bits[FB-1] !== 1'b1) mon_errors = mon_errors + 1;
`ifdef UART_CONSOLE_PARITY_EN
                        if (mon_bits[9] !== ^mon_bits[8:1]) mon_errors = mon_errors + 1;
                        rx_par.push_back(mon_bits[9]);
`endif
                        rx_bytes.push_back(mon_bits[8:1]);
                        rx_raw.push_back(mon_bits);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic [10:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_CONSOLE_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    // One bus cycle; the model applies the acceptance rules at the same edge.
    task automatic bus_access(input logic en, input logic st, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk);
        mem_en = en;
        mem_state = st;
        mem_addr = addr;
        mem_data = data;
        mem_mask = mask;
        @(posedge clk);
        if (en && st == 1'b1 && addr == CON_ADDR && mask[3]) begin
            if (model_acc - frames_started < DEPTH) begin
                exp_q.push_back(data[7:0]);
                model_acc = model_acc + 1;
            end else begin
                model_drop = 1'b1;
            end
        end
    endtask

    task automatic bus_idle;
        @(negedge clk);
        mem_en = 1'b0;
        mem_state = 1'b0;
        mem_mask = 4'b0000;
    endtask

    task automatic wait_rx(input int target, output bit timed_out);
        int budget;
        budget = (target - rx_bytes.size() + 2) * FRAME_CYC + 200;
        timed_out = 1'b0;
        while (rx_bytes.size() < target) begin
            if (budget == 0) begin
                timed_out = 1'b1;
                break;
            end
            budget = budget - 1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compared++; if (tx !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        compared++; if (fifo_full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %b want 0", fifo_full); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b want 0", overflow); end
    endtask

    task automatic test_single_byte;
        int base, err0;
        bit to;
        base = rx_bytes.size();
        err0 = mon_errors;
        exp_q.delete();
        bus_access(1'b1, 1'b1, CON_ADDR, 32'h0000_0041, 4'b1111);
        bus_idle();
        compared++; if (tx !== 1'b1) begin mismatched++; $display("[TB] FAIL no_bypass_tx: got %b want 1", tx); end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL queued_busy: got %b want 1", busy); end
        @(negedge clk);
        compared++; if (tx !== 1'b0) begin mismatched++; $display("[TB] FAIL start_latency_tx: got %b want 0", tx); end
        wait_rx(base + 1, to);
        compared++; if (to) begin mismatched++; $display("[TB] FAIL single_timeout: got %0d frames want %0d", rx_bytes.size() - base, 1); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL busy_after_stop: got %b want 0", busy); end
        compared++;
        if (rx_raw.size() <= base || rx_raw[base] !== frame_of(8'h41)) begin
            mismatched++; $display("[TB] FAIL single_frame: got %b want %b", rx_raw[base], frame_of(8'h41));
        end
        compared++; if (mon_errors != err0) begin mismatched++; $display("[TB] FAIL single_timing: got %0d errors want 0", mon_errors - err0); end
    endtask

    task automatic test_ignored;
        int base, st0;
        bit low_seen, busy_seen;
        base = rx_bytes.size();
        st0 = frames_started;
        exp_q.delete();
        bus_access(1'b1, 1'b1, CON_ADDR + 32'h4, 32'h0000_0033, 4'b1111);
        bus_access(1'b1, 1'b0, CON_ADDR, 32'h0000_0034, 4'b1111);
        bus_access(1'b1, 1'b1, CON_ADDR, 32'h0000_0035, 4'b0111);
        bus_idle();
        low_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (3 * FRAME_CYC) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
            if (busy !== 1'b0) busy_seen = 1'b1;
        end
        compared++; if (low_seen) begin mismatched++; $display("[TB] FAIL ignored_tx: tx left idle, want steady 1"); end
        compared++; if (busy_seen) begin mismatched++; $display("[TB] FAIL ignored_busy: busy rose, want 0"); end
        compared++; if (frames_started != st0 || rx_bytes.size() != base) begin
            mismatched++; $display("[TB] FAIL ignored_frames: got %0d want 0", frames_started - st0);
        end
    endtask

    task automatic test_back_to_back;
        int base;
        bit to;
        base = rx_bytes.size();
        exp_q.delete();
        bus_access(1'b1, 1'b1, CON_ADDR, 32'h0000_000A, 4'b1000);
        bus_access(1'b1, 1'b1, CON_ADDR, 32'h0000_000D, 4'b1111);
        bus_idle();
        wait_rx(base + 2, to);
        compared++; if (to) begin mismatched++; $display("[TB] FAIL b2b_timeout: got %0d frames want 2", rx_bytes.size() - base); end
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (base + i >= rx_bytes.size() || rx_bytes[base+i] !== exp_q[i]) begin
                mismatched++; $display("[TB] FAIL b2b_byte%0d: got %h want %h", i, rx_bytes[base+i], exp_q[i]);
            end
        end
        compared++;
        if (start_cycles.size() < base + 2 || start_cycles[base+1] - start_cycles[base] != FRAME_CYC) begin
            mismatched++; $display("[TB] FAIL b2b_gap: got %0d cycles want %0d", start_cycles[base+1] - start_cycles[base], FRAME_CYC);
        end
    endtask

`ifdef UART_CONSOLE_PARITY_EN
    task automatic test_parity;
        int base;
        bit to;
        base = rx_bytes.size();
        exp_q.delete();
        bus_access(1'b1, 1'b1, CON_ADDR, 32'h0000_0007, 4'b1111);
        bus_access(1'b1, 1'b1, CON_ADDR, 32'h0000_0003, 4'b1111);
        bus_idle();
        wait_rx(base + 2, to);
        compared++; if (to) begin mismatched++; $display("[TB] FAIL parity_timeout: got %0d frames want 2", rx_bytes.size() - base); end
        compared++; if (rx_par[base] !== 1'b1) begin mismatched++; $display("[TB] FAIL parity_07: got %b want 1", rx_par[base]); end
        compared++; if (rx_par[base+1] !== 1'b0) begin mismatched++; $display("[TB] FAIL parity_03: got %b want 0", rx_par[base+1]); end
        compared++; if (rx_raw[base] !== frame_of(8'h07)) begin mismatched++; $display("[TB] FAIL parity_frame07: got %b want %b", rx_raw[base], frame_of(8'h07)); end
        compared++; if (rx_raw[base+1] !== frame_of(8'h03)) begin mismatched++; $display("[TB] FAIL parity_frame03: got %b want %b", rx_raw[base+1], frame_of(8'h03)); end
    endtask
`endif

    task automatic test_random;
        int base, err0, n, kind;
        bit to;
        for (int iter = 0; iter < 6; iter++) begin
            base = rx_bytes.size();
            err0 = mon_errors;
            exp_q.delete();
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) begin
                kind = $urandom_range(0, 5);
                if (kind == 0) bus_access(1'b1, 1'b1, CON_ADDR + 32'(4 * $urandom_range(1, 100)), $urandom, 4'b1111);
                else if (kind == 1) bus_access(1'b1, 1'b0, CON_ADDR, $urandom, 4'b1111);
                else if (kind == 2) bus_access(1'b1, 1'b1, CON_ADDR, $urandom, {1'b0, 3'($urandom)});
                bus_access(1'b1, 1'b1, CON_ADDR, $urandom, {1'b1, 3'($urandom)});
                if ($urandom_range(0, 1) == 1) begin
                    bus_idle();
                    repeat ($urandom_range(0, 30)) @(posedge clk);
                end
            end
            bus_idle();
            wait_rx(base + exp_q.size(), to);
            compared++; if (to) begin mismatched++; $display("[TB] FAIL rand%0d_timeout: got %0d frames want %0d", iter, rx_bytes.size() - base, exp_q.size()); end
            for (int i = 0; i < exp_q.size(); i++) begin
                compared++;
                if (base + i >= rx_bytes.size() || rx_bytes[base+i] !== exp_q[i]) begin
                    mismatched++; $display("[TB] FAIL rand%0d_byte%0d: got %h want %h", iter, i, rx_bytes[base+i], exp_q[i]);
                end
            end
            compared++; if (mon_errors != err0) begin mismatched++; $display("[TB] FAIL rand%0d_framing: got %0d errors want 0", iter, mon_errors - err0); end
            compared++; if (overflow !== model_drop) begin mismatched++; $display("[TB] FAIL rand%0d_overflow: got %b want %b", iter, overflow, model_drop); end
        end
    endtask

    task automatic test_overflow;
        int base, st0, budget;
        bit to;
        base = rx_bytes.size();
        st0 = frames_started;
        exp_q.delete();
        bus_access(1'b1, 1'b1, CON_ADDR, $urandom, 4'b1111);
        bus_idle();
        budget = 50;
        while (frames_started == st0 && budget > 0) begin
            budget = budget - 1;
            @(posedge clk);
        end
        compared++; if (frames_started == st0) begin mismatched++; $display("[TB] FAIL ovf_first_start: got 0 frames started want 1"); end
        for (int k = 0; k < DEPTH + 1; k++) bus_access(1'b1, 1'b1, CON_ADDR, $urandom, 4'b1111);
        #1;
        compared++; if (fifo_full !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_full: got %b want 1", fifo_full); end
        compared++; if (overflow !== model_drop) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b want %b", overflow, model_drop); end
        bus_idle();
        wait_rx(base + exp_q.size(), to);
        repeat (2 * FRAME_CYC) @(posedge clk);
        #1;
        compared++; if (rx_bytes.size() != base + exp_q.size()) begin
            mismatched++; $display("[TB] FAIL ovf_count: got %0d frames want %0d", rx_bytes.size() - base, exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            compared++;
            if (base + i >= rx_bytes.size() || rx_bytes[base+i] !== exp_q[i]) begin
                mismatched++; $display("[TB] FAIL ovf_byte%0d: got %h want %h", i, rx_bytes[base+i], exp_q[i]);
            end
        end
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_hold: got %b want 1", overflow); end
        compared++; if (fifo_full !== 1'b0 || busy !== 1'b0) begin
            mismatched++; $display("[TB] FAIL ovf_drain: got full=%b busy=%b want 0/0", fifo_full, busy);
        end
    endtask

    task automatic test_reset_midframe;
        int base, st0, budget;
        bit low_seen;
        base = rx_bytes.size();
        st0 = frames_started;
        exp_q.delete();
        bus_access(1'b1, 1'b1, CON_ADDR, 32'h0000_0055, 4'b1111);
        for (int k = 0; k < 3; k++) bus_access(1'b1, 1'b1, CON_ADDR, $urandom, 4'b1111);
        bus_idle();
        budget = 50;
        while (frames_started == st0 && budget > 0) begin
            budget = budget - 1;
            @(posedge clk);
        end
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        compared++; if (tx !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_tx: got %b want 1", tx); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
        compared++; if (overflow !== 1'b0 || fifo_full !== 1'b0) begin
            mismatched++; $display("[TB] FAIL midreset_flags: got ovf=%b full=%b want 0/0", overflow, fifo_full);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_drop = 1'b0;
        st0 = frames_started;
        model_acc = frames_started;
        low_seen = 1'b0;
        repeat (3 * FRAME_CYC) begin
            @(negedge clk);
            if (tx !== 1'b1) low_seen = 1'b1;
        end
        compared++; if (low_seen || frames_started != st0) begin
            mismatched++; $display("[TB] FAIL midreset_no_frame: got %0d new frames want 0", frames_started - st0);
        end
        compared++; if (rx_bytes.size() != base) begin mismatched++; $display("[TB] FAIL midreset_rx: got %0d frames want 0", rx_bytes.size() - base); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_busy_after: got %b want 0", busy); end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        model_acc = 0;
        model_drop = 1'b0;
        reset = 1'b1;
        mem_en = 1'b0;
        mem_state = 1'b0;
        mem_addr = '0;
        mem_mask = '0;
        mem_data = '0;
        test_reset();
        test_single_byte();
        test_ignored();
        test_back_to_back();
`ifdef UART_CONSOLE_PARITY_EN
        test_parity();
`endif
        test_random();
        test_overflow();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
